// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit: op codes, FSM states, iteration count.
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // MULT and DIV treat operands as two's complement; the unsigned forms do not.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the control unit (master) and the multiply-divide unit (slave).
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] sr_nxt
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Multiply: {acc,sr} shifts right absorbing the adder carry; divide: {acc,sr} shifts left.
  always_comb begin
    sum_s     = {1'b0, acc} + ({1'b0, opnd} & {(WIDTH + 1){sr[0]}});
    shifted_s = {acc, sr[WIDTH-1]};
    diff_s    = {1'b0, shifted_s} - {2'b00, opnd};
    acc_nxt   = acc;
    sr_nxt    = sr;
    if (div_mode) begin
      if (!diff_s[WIDTH+1]) begin
        acc_nxt = diff_s[WIDTH-1:0];
        sr_nxt  = {sr[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted_s[WIDTH-1:0];
        sr_nxt  = {sr[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum_s[WIDTH:1];
      sr_nxt  = {sum_s[0], sr[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply-divide unit with MTHI/MTLO and a busy stall indication.
// Define FAST_MULT_EN to compute MULT/MULTU in a single cycle; DIV/DIVU stay iterative.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MDU_ITER
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(ITER + 1);

  mdu_state_e       state_r, state_nxt_s;
  logic [WIDTH-1:0] acc_r, sr_r, opnd_r, hi_r, lo_r;
  logic [WIDTH-1:0] acc_nxt_s, sr_nxt_s, opnd_nxt_s, hi_nxt_s, lo_nxt_s;
  logic [WIDTH-1:0] step_acc_s, step_sr_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             div_r, res_neg_r, rem_neg_r, dz_r;
  logic             div_nxt_s, res_neg_nxt_s, rem_neg_nxt_s, dz_nxt_s;
  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, quo_s, rem_s;
  logic [2*WIDTH-1:0] prod_s;
`ifdef FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod_s;
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (div_r),
    .acc      (acc_r),
    .sr       (sr_r),
    .opnd     (opnd_r),
    .acc_nxt  (step_acc_s),
    .sr_nxt   (step_sr_s)
  );

  // Operand magnitudes at issue and sign-corrected results for the FIX cycle.
  always_comb begin
    a_neg_s = op_is_signed(bus.op) & bus.a[WIDTH-1];
    b_neg_s = op_is_signed(bus.op) & bus.b[WIDTH-1];
    a_mag_s = a_neg_s ? -bus.a : bus.a;
    b_mag_s = b_neg_s ? -bus.b : bus.b;
    prod_s  = res_neg_r ? -{acc_r, sr_r} : {acc_r, sr_r};
    quo_s   = dz_r ? {WIDTH{1'b1}} : (res_neg_r ? -sr_r : sr_r);
    rem_s   = rem_neg_r ? -acc_r : acc_r;
`ifdef FAST_MULT_EN
    // Truncating the product of sign-extended operands yields the signed product.
    if (op_is_signed(bus.op)) begin
      fast_prod_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
    end else begin
      fast_prod_s = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
    end
`endif
  end

  // Next-state and datapath next values; a start is only honoured in IDLE or DONE.
  always_comb begin
    state_nxt_s   = state_r;
    acc_nxt_s     = acc_r;
    sr_nxt_s      = sr_r;
    opnd_nxt_s    = opnd_r;
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    cnt_nxt_s     = cnt_r;
    div_nxt_s     = div_r;
    res_neg_nxt_s = res_neg_r;
    rem_neg_nxt_s = rem_neg_r;
    dz_nxt_s      = dz_r;
    case (state_r)
      IDLE, DONE: begin
        if (state_r == DONE) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = IDLE;
        end
        if (bus.start) begin
          case (bus.op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
`ifdef FAST_MULT_EN
              if (!bus.op[1]) begin
                {hi_nxt_s, lo_nxt_s} = fast_prod_s;
                state_nxt_s          = DONE;
              end else begin
`else
              begin
`endif
                // Divide keeps the dividend in sr and divisor in opnd; multiply the reverse.
                state_nxt_s   = RUN;
                acc_nxt_s     = {WIDTH{1'b0}};
                sr_nxt_s      = bus.op[1] ? a_mag_s : b_mag_s;
                opnd_nxt_s    = bus.op[1] ? b_mag_s : a_mag_s;
                cnt_nxt_s     = CW'(ITER);
                div_nxt_s     = bus.op[1];
                res_neg_nxt_s = a_neg_s ^ b_neg_s;
                rem_neg_nxt_s = a_neg_s;
                dz_nxt_s      = bus.op[1] && (bus.b == {WIDTH{1'b0}});
              end
            end
            MDU_MTHI: hi_nxt_s = bus.a;
            MDU_MTLO: lo_nxt_s = bus.a;
            default: ;
          endcase
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      RUN: begin
        acc_nxt_s = step_acc_s;
        sr_nxt_s  = step_sr_s;
        cnt_nxt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIX: begin
        if (div_r) begin
          hi_nxt_s = rem_s;
          lo_nxt_s = quo_s;
        end else begin
          {hi_nxt_s, lo_nxt_s} = prod_s;
        end
        state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      acc_r     <= {WIDTH{1'b0}};
      sr_r      <= {WIDTH{1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      div_r     <= 1'b0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      dz_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      acc_r     <= acc_nxt_s;
      sr_r      <= sr_nxt_s;
      opnd_r    <= opnd_nxt_s;
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      cnt_r     <= cnt_nxt_s;
      div_r     <= div_nxt_s;
      res_neg_r <= res_neg_nxt_s;
      rem_neg_r <= rem_neg_nxt_s;
      dz_r      <= dz_nxt_s;
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = (state_r == RUN) || (state_r == FIX);
  assign bus.done = (state_r == DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mh, output logic [31:0] ml);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    mh = exp_hi;
    ml = exp_lo;
    case (o)
      3'd0: begin p = 64'(sx * sy); mh = p[63:32]; ml = p[31:0]; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; mh = p[63:32]; ml = p[31:0]; end
      3'd2: begin
        if (y == 32'd0) begin mh = x; ml = 32'hFFFF_FFFF; end
        else begin q = sx / sy; r = sx % sy; mh = r[31:0]; ml = q[31:0]; end
      end
      3'd3: begin
        if (y == 32'd0) begin mh = x; ml = 32'hFFFF_FFFF; end
        else begin mh = x % y; ml = x / y; end
      end
      3'd4: mh = x;
      3'd5: ml = x;
      default: ;
    endcase
  endfunction

  function automatic int exp_busy(input logic [2:0] o);
`ifdef FAST_MULT_EN
    if (!o[1]) return 0;
`endif
    return 33;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'($urandom_range(0, 7)); bus.a = $urandom; bus.b = $urandom;
  endtask

  // Samples 1ns after each edge until done; optionally injects an MTLO while busy.
  task automatic wait_for_done(input int inj_at, output int busy_n, output bit seen, output bit partial);
    busy_n = 0; seen = 1'b0; partial = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.busy === 1'b1) begin
        busy_n++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo) partial = 1'b1;
      end
      if (bus.done === 1'b1) begin seen = 1'b1; break; end
      if (i == inj_at) begin
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h55;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input int inj_at);
    logic [31:0] eh, el;
    int busy_n;
    bit seen, partial;
    model(o, x, y, eh, el);
    issue(o, x, y);
    wait_for_done(inj_at, busy_n, seen, partial);
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_timeout: done never seen op=%0d", name, o); end
    checks++;
    if (busy_n != exp_busy(o)) begin errors++; $display("FAIL %s_busy: busy cycles=%0d expected %0d", name, busy_n, exp_busy(o)); end
    checks++;
    if (partial) begin errors++; $display("FAIL %s_partial: hi/lo changed while busy", name); end
    checks++;
    if (bus.hi !== eh || bus.lo !== el) begin
      errors++; $display("FAIL %s_result: op=%0d a=%h b=%h hi=%h lo=%h expected hi=%h lo=%h", name, o, x, y, bus.hi, bus.lo, eh, el);
    end
    exp_hi = eh; exp_lo = el;
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s_done_pulse: done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
    end
  endtask

  task automatic run_move(input string name, input logic [2:0] o, input logic [31:0] x);
    logic [31:0] eh, el;
    model(o, x, 32'd0, eh, el);
    issue(o, x, 32'd0);
    checks++;
    if (bus.hi !== eh || bus.lo !== el || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL %s: hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=0 done=0", name, bus.hi, bus.lo, bus.busy, bus.done, eh, el);
    end
    exp_hi = eh; exp_lo = el;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hFFFF_FFFF; bus.b = 32'd1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; bus.start = 1'b0;
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b expected all zero", bus.hi, bus.lo, bus.busy, bus.done);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.hi !== 32'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored: hi=%h busy=%b expected 0 0", bus.hi, bus.busy);
    end
  endtask

  task automatic test_mult();
    run_check("mult", 3'd0, 32'hFFFF_FFFE, 32'h3, -1);
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_const: hi=%h lo=%h expected ffffffff fffffffa", bus.hi, bus.lo);
    end
    run_check("multu", 3'd1, 32'hFFFF_FFFE, 32'h3, -1);
    checks++;
    if (bus.hi !== 32'h2 || bus.lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL multu_const: hi=%h lo=%h expected 00000002 fffffffa", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    run_check("div", 3'd2, 32'hFFFF_FFF9, 32'h2, -1);
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_const: hi=%h lo=%h expected ffffffff fffffffd", bus.hi, bus.lo);
    end
    run_check("divu", 3'd3, 32'h7, 32'h2, -1);
    checks++;
    if (bus.hi !== 32'h1 || bus.lo !== 32'h3) begin
      errors++; $display("FAIL divu_const: hi=%h lo=%h expected 1 3", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div_edge();
    run_check("divu_zero", 3'd3, 32'h1234, 32'h0, -1);
    checks++;
    if (bus.hi !== 32'h1234 || bus.lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL divu_zero_const: hi=%h lo=%h expected 1234 ffffffff", bus.hi, bus.lo);
    end
    run_check("div_zero_neg", 3'd2, 32'hFFFF_FFF9, 32'h0, -1);
    run_check("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000) begin
      errors++; $display("FAIL div_ovf_const: hi=%h lo=%h expected 0 80000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_moves();
    run_move("mthi", 3'd4, 32'hA5A5_A5A5);
    checks++;
    if (bus.hi !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL mthi_const: hi=%h expected a5a5a5a5", bus.hi);
    end
    run_move("mtlo", 3'd5, 32'h0BAD_F00D);
    run_move("noop", 3'd6, 32'h1111_2222);
    // MTLO issued mid-divide must be dropped; lo ends as the quotient.
    run_check("div_mtlo_ignored", 3'd3, 32'd1000, 32'd7, 5);
    checks++;
    if (bus.lo !== 32'd142 || bus.hi !== 32'd6) begin
      errors++; $display("FAIL mtlo_busy_ignored: hi=%h lo=%h expected 6 8e", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_abort();
    issue(3'd2, 32'h7FFF_0000, 32'h3);
    repeat (9) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_abort: hi=%h lo=%h busy=%b done=%b expected all zero", bus.hi, bus.lo, bus.busy, bus.done);
    end
    exp_hi = 32'd0; exp_lo = 32'd0;
    run_check("multu_after_reset", 3'd1, 32'd3, 32'd5, -1);
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd15) begin
      errors++; $display("FAIL multu_3x5: hi=%h lo=%h expected 0 f", bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h1, l1, h2, l2;
    int busy_n;
    bit seen, partial;
    model(3'd2, 32'hFFFF_8000, 32'd100, h1, l1);
    issue(3'd2, 32'hFFFF_8000, 32'd100);
    wait_for_done(-1, busy_n, seen, partial);
    checks++;
    if (!seen || bus.hi !== h1 || bus.lo !== l1) begin
      errors++; $display("FAIL b2b_first: seen=%b hi=%h lo=%h expected hi=%h lo=%h", seen, bus.hi, bus.lo, h1, l1);
    end
    exp_hi = h1; exp_lo = l1;
    model(3'd0, 32'h8000_0000, 32'h8000_0000, h2, l2);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h8000_0000; bus.b = 32'h8000_0000;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    wait_for_done(-1, busy_n, seen, partial);
    checks++;
    if (!seen || busy_n != exp_busy(3'd0) || partial || bus.hi !== h2 || bus.lo !== l2) begin
      errors++; $display("FAIL b2b_second: seen=%b busy=%0d partial=%b hi=%h lo=%h expected busy=%0d hi=%h lo=%h", seen, busy_n, partial, bus.hi, bus.lo, exp_busy(3'd0), h2, l2);
    end
    exp_hi = h2; exp_lo = l2;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] x, y;
    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: x = 32'($urandom_range(0, 255));
        default: ;
      endcase
      if (o <= 3'd3) run_check("random", o, x, y, -1);
      else run_move("random_move", o, x);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd6; bus.a = 32'd0; bus.b = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_moves();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
